// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad column by column, debounces whole frames and strobes each accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] keycode,
  output logic [7:0] keycode_previous,
  output logic       strobe,
  output logic       key_held
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  typedef enum logic {IDLE, HELD} state_t;
  state_t state, state_nx;
  logic [3:0] sync1, sync2;
  logic [SW-1:0] slot;
  logic [7:0] acc_code, frame_code, cand, cand_nx;
  logic acc_multi, frame_multi, sample, frame_end, hit, accept, release_key;
  logic [DW-1:0] stable, stable_nx;
  assign sample = slot == SW'(SCAN_DIV - 1);
  assign frame_end = sample && col_out[3];
  // Running frame result including the column being sampled right now.
  assign frame_multi = acc_multi || (|sync2 && (|acc_code || !$onehot(sync2)));
  assign frame_code = frame_multi ? 8'h00 : |acc_code ? acc_code : |sync2 ? {sync2, col_out} : 8'h00;
  assign cand_nx = frame_multi ? cand : frame_code;
  assign stable_nx = frame_multi ? '0
                   : frame_code != cand ? DW'(1)
                   : stable == DW'(DEBOUNCE) ? stable : stable + DW'(1);
  assign hit = frame_end && stable_nx == DW'(DEBOUNCE);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      slot <= '0;
      col_out <= 4'b0001;
      acc_code <= '0;
      acc_multi <= 1'b0;
      cand <= '0;
      stable <= '0;
    end else begin
      sync1 <= row_in;
      sync2 <= sync1;
      slot <= sample ? '0 : slot + SW'(1);
      if (sample) col_out <= {col_out[2:0], col_out[3]};
      if (sample) acc_code <= frame_end ? 8'h00 : frame_code;
      if (sample) acc_multi <= frame_end ? 1'b0 : frame_multi;
      if (frame_end) cand <= cand_nx;
      if (frame_end) stable <= stable_nx;
    end
  end
  // A release is only ever accepted from HELD; roll-over to a new code counts as a press.
  always_comb begin
    accept = hit && |cand_nx && (state == IDLE || cand_nx != keycode);
    release_key = hit && state == HELD && cand_nx == 8'h00;
  end
  always_comb state_nx = accept ? HELD : release_key ? IDLE : state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      strobe <= 1'b0;
      keycode <= '0;
      keycode_previous <= '0;
      key_held <= 1'b0;
    end else begin
      state <= state_nx;
      strobe <= accept;
      if (accept) keycode_previous <= keycode;
      if (accept) keycode <= cand_nx;
      if (accept || release_key) key_held <= accept;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model driving rows from col_out, with a scoreboard of expected strobes.
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] row_in, col_out;
  logic [7:0] keycode, keycode_previous;
  logic strobe, key_held;
  logic [15:0] keys = '0;
  logic [15:0] exp_q[$];
  logic [15:0] e;
  logic strobe_d = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE(3)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out), .keycode(keycode),
    .keycode_previous(keycode_previous), .strobe(strobe), .key_held(key_held)
  );
  // Key at row r, column c is bit r*4+c of keys.
  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++) row_in[r] = |(keys[r*4 +: 4] & col_out);
  end
  always @(negedge clk) begin
    if (strobe) begin
      n_checks++;
      if (strobe_d) begin
        n_fail++;
        $display("FAIL strobe_width: strobe high on consecutive cycles, required 1 cycle");
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: keycode=%h prev=%h, required no strobe", keycode, keycode_previous);
      end else begin
        e = exp_q.pop_front();
        if ({keycode, keycode_previous} !== e) begin
          n_fail++;
          $display("FAIL strobe_codes: keycode=%h prev=%h, required keycode=%h prev=%h",
                   keycode, keycode_previous, e[15:8], e[7:0]);
        end
      end
    end
    strobe_d = strobe;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  task automatic wait_frames(input int n);
    int b;
    for (int i = 0; i < n; i++) begin
      b = 0;
      do begin @(posedge clk); #1; b++; end while (col_out !== 4'b1000 && b < 200);
      do begin @(posedge clk); #1; b++; end while (col_out !== 4'b0001 && b < 200);
      if (b >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_timeout: col_out=%b, no frame boundary within 200 cycles", col_out);
      end
    end
  endtask
  task automatic check_pending(input string name, input int want);
    n_checks++;
    if (exp_q.size() != want) begin
      n_fail++;
      $display("FAIL %s: pending strobes=%0d, required %0d", name, exp_q.size(), want);
    end
  endtask
  task automatic check_held(input string name, input logic want);
    n_checks++;
    if (key_held !== want) begin
      n_fail++;
      $display("FAIL %s: key_held=%b, required %b", name, key_held, want);
    end
  endtask
  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({col_out, keycode, keycode_previous, strobe, key_held} !== {4'b0001, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s: col=%b kc=%h prev=%h strobe=%b held=%b, required col=0001 kc=00 prev=00 strobe=0 held=0",
               name, col_out, keycode, keycode_previous, strobe, key_held);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    keys = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    @(negedge clk) rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (col_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL col_slot0: col_out=%b on cycle 7, required 0001", col_out);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (col_out !== 4'b0010) begin
      n_fail++;
      $display("FAIL col_advance: col_out=%b on cycle 8, required 0010", col_out);
    end
  endtask
  task automatic test_single_press();
    wait_frames(1);
    keys[5] = 1'b1;
    exp_q.push_back({8'h22, 8'h00});
    wait_frames(2);
    check_pending("press_not_early", 1);
    wait_frames(2);
    check_pending("press_strobed", 0);
    for (int i = 0; i < 11; i++) begin
      wait_frames(1);
      check_held("hold_key_held", 1'b1);
    end
  endtask
  task automatic test_repeat_press();
    keys[5] = 1'b0;
    wait_frames(2);
    check_held("release_not_early", 1'b1);
    wait_frames(1);
    check_held("release_after_3", 1'b0);
    n_checks++;
    if (keycode !== 8'h22) begin
      n_fail++;
      $display("FAIL keycode_hold: keycode=%h after release, required 22", keycode);
    end
    wait_frames(1);
    keys[5] = 1'b1;
    exp_q.push_back({8'h22, 8'h22});
    wait_frames(4);
    check_pending("repeat_strobed", 0);
    check_held("repeat_held", 1'b1);
  endtask
  task automatic test_bounce();
    keys[5] = 1'b0;
    wait_frames(4);
    check_held("bounce_idle", 1'b0);
    for (int i = 0; i < 6; i++) begin
      keys[7] = (i % 2 == 0);
      wait_frames(1);
    end
    check_held("bounce_no_press", 1'b0);
    keys[7] = 1'b1;
    exp_q.push_back({8'h28, 8'h22});
    wait_frames(2);
    check_pending("bounce_not_early", 1);
    wait_frames(2);
    check_pending("bounce_strobed", 0);
  endtask
  task automatic test_multi_key();
    keys[7] = 1'b0;
    wait_frames(4);
    keys[15] = 1'b1;
    keys[14] = 1'b1;
    wait_frames(5);
    check_held("multi_no_press", 1'b0);
    n_checks++;
    if (keycode !== 8'h28) begin
      n_fail++;
      $display("FAIL multi_keycode: keycode=%h, required 28", keycode);
    end
    keys[15] = 1'b0;
    exp_q.push_back({8'h84, 8'h28});
    wait_frames(4);
    check_pending("multi_release_strobed", 0);
    check_held("multi_single_held", 1'b1);
  endtask
  task automatic test_reset_mid_debounce();
    keys[14] = 1'b0;
    wait_frames(4);
    keys[11] = 1'b1;
    wait_frames(2);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk) rst = 1'b0;
    exp_q.push_back({8'h48, 8'h00});
    wait_frames(2);
    check_pending("post_reset_not_early", 1);
    wait_frames(2);
    check_pending("post_reset_strobed", 0);
  endtask
  initial begin
    test_reset();
    test_single_press();
    test_repeat_press();
    test_bounce();
    test_multi_key();
    test_reset_mid_debounce();
    check_pending("scoreboard_empty", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
